// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit.
//   - Memory access-type encodings understood by the data memory block.
//   - RV32I load/store funct3 encodings.
//   - lsu_state_t FSM state encoding.
//   - Helpers that decode funct3 into access size, legality and memory access type.
package load_store_unit_pkg;

  // Memory access-type encodings (existing memory block contract).
  localparam logic [1:0] BYTE_MEM_ACCESS = 2'b00;
  localparam logic [1:0] HALF_MEM_ACCESS = 2'b01;
  localparam logic [1:0] WORD_MEM_ACCESS = 2'b10;

  // RV32I funct3 for loads.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  // RV32I funct3 for stores.
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    SPLIT  = 2'd2,
    RESP   = 2'd3
  } lsu_state_t;

  // Access size minus one, in bytes: 0 = byte, 1 = half, 3 = word.
  // Doubles as the index of the last beat of a split access.
  function automatic logic [1:0] f3_size_m1(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   f3_size_m1 = 2'd0;
      2'b01:   f3_size_m1 = 2'd1;
      default: f3_size_m1 = 2'd3;
    endcase
  endfunction

  function automatic logic [1:0] f3_mem_type(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   f3_mem_type = BYTE_MEM_ACCESS;
      2'b01:   f3_mem_type = HALF_MEM_ACCESS;
      default: f3_mem_type = WORD_MEM_ACCESS;
    endcase
  endfunction

  function automatic logic f3_legal(input logic write, input logic [2:0] f3);
    if (write)
      f3_legal = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    else
      f3_legal = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                 (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

endpackage

// File: rtl/load_store_unit_extend.sv
// load_extend: combinational sign/zero extension of an assembled read word.
// Ports:
//   funct3_i  load funct3 (LB/LH sign-extend, LBU/LHU zero-extend, LW pass)
//   data_i    assembled little-endian read data, meaningful bytes at the bottom
//   data_o    extended result
module load_extend
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (funct3_i)
      F3_LB:   data_o = {{24{data_i[7]}}, data_i[7:0]};
      F3_LH:   data_o = {{16{data_i[15]}}, data_i[15:0]};
      F3_LBU:  data_o = {24'h0, data_i[7:0]};
      F3_LHU:  data_o = {16'h0, data_i[15:0]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: turns an execute-stage load/store request into memory port
// transactions and returns one registered response pulse per request.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake; req_write, req_funct3,
//                           req_addr, req_wdata describe the access
//   rsp_valid               one-cycle response pulse (no backpressure)
//   rsp_rdata, rsp_fault    extended load data / access fault
//   mem_*                   registered memory port; mem_data_out is the
//                           memory's combinational, zero-extended read data
//
// Handshake: a request transfers on a posedge where req_valid && req_ready;
// req_ready is high only in IDLE, so at most one request is in flight and its
// response pulses before the next one can be accepted.
//
// Build option: defining MISALIGN_TRAP_EN makes misaligned half/word accesses
// fault instead of being split into byte beats; the SPLIT path is then absent.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int WORDS      = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_fault,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_write,
  output logic                  mem_read,
  output logic [1:0]            mem_access_type,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  localparam logic [DATA_WIDTH-1:0] ADDR_LIMIT = DATA_WIDTH'(WORDS * 4);

  lsu_state_t            state_q, state_d;
  logic                  write_q, write_d;
  logic [2:0]            funct3_q, funct3_d;
  logic                  fault_q, fault_d;
  logic [DATA_WIDTH-1:0] asm_q, asm_d;
  logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_in_q, mem_data_in_d;
  logic                  mem_write_q, mem_write_d;
  logic                  mem_read_q, mem_read_d;
  logic [1:0]            mem_type_q, mem_type_d;
`ifndef MISALIGN_TRAP_EN
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [1:0]            beat_q, beat_d;
  logic [1:0]            next_beat;
`endif

  // Request decode, evaluated against the live request at accept time.
  logic [1:0]            req_size_m1;
  logic [DATA_WIDTH-1:0] req_last;
  logic                  req_misal;
  logic                  req_fault;
  logic [DATA_WIDTH-1:0] req_wmask;

  assign req_size_m1 = f3_size_m1(req_funct3);
  // Last byte touched; a wrapped sum is still caught because req_addr itself
  // must then be at or beyond the limit.
  assign req_last    = req_addr + DATA_WIDTH'(req_size_m1);
  assign req_misal   = ((req_size_m1 == 2'd1) && req_addr[0]) ||
                       ((req_size_m1 == 2'd3) && (req_addr[1:0] != 2'b00));

  always_comb begin
    req_fault = !f3_legal(req_write, req_funct3) ||
                (req_addr >= ADDR_LIMIT) || (req_last >= ADDR_LIMIT);
`ifdef MISALIGN_TRAP_EN
    req_fault = req_fault || req_misal;
`endif
  end

  always_comb begin
    case (req_size_m1)
      2'd0:    req_wmask = {24'h0, req_wdata[7:0]};
      2'd1:    req_wmask = {16'h0, req_wdata[15:0]};
      default: req_wmask = req_wdata;
    endcase
  end

`ifndef MISALIGN_TRAP_EN
  assign next_beat = beat_q + 2'd1;
`endif

  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    funct3_d      = funct3_q;
    fault_d       = fault_q;
    asm_d         = asm_q;
    mem_addr_d    = mem_addr_q;
    mem_data_in_d = mem_data_in_q;
    mem_write_d   = mem_write_q;
    mem_read_d    = mem_read_q;
    mem_type_d    = mem_type_q;
`ifndef MISALIGN_TRAP_EN
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    beat_d        = beat_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          fault_d  = req_fault;
          asm_d    = '0;
`ifndef MISALIGN_TRAP_EN
          addr_d   = req_addr;
          wdata_d  = req_wdata;
`endif
          if (req_fault) begin
            state_d = RESP;
`ifndef MISALIGN_TRAP_EN
          end else if (req_misal) begin
            state_d       = SPLIT;
            beat_d        = 2'd0;
            mem_addr_d    = req_addr;
            mem_type_d    = BYTE_MEM_ACCESS;
            mem_read_d    = !req_write;
            mem_write_d   = req_write;
            mem_data_in_d = req_write ? {24'h0, req_wdata[7:0]} : '0;
`endif
          end else begin
            state_d       = ACCESS;
            mem_addr_d    = req_addr;
            mem_type_d    = f3_mem_type(req_funct3);
            mem_read_d    = !req_write;
            mem_write_d   = req_write;
            mem_data_in_d = req_write ? req_wmask : '0;
          end
        end
      end
      ACCESS: begin
        if (!write_q) asm_d = mem_data_out;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        state_d     = RESP;
      end
`ifndef MISALIGN_TRAP_EN
      SPLIT: begin
        // Byte beat k lands in assembly bits [8k+7:8k] (little-endian).
        if (!write_q) asm_d[8*beat_q +: 8] = mem_data_out[7:0];
        if (beat_q == f3_size_m1(funct3_q)) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = RESP;
        end else begin
          beat_d        = next_beat;
          mem_addr_d    = addr_q + DATA_WIDTH'(next_beat);
          mem_data_in_d = write_q ? {24'h0, wdata_q[8*next_beat +: 8]} : '0;
        end
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      write_q       <= 1'b0;
      funct3_q      <= 3'b000;
      fault_q       <= 1'b0;
      asm_q         <= '0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      mem_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_type_q    <= WORD_MEM_ACCESS;
`ifndef MISALIGN_TRAP_EN
      addr_q        <= '0;
      wdata_q       <= '0;
      beat_q        <= 2'd0;
`endif
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      funct3_q      <= funct3_d;
      fault_q       <= fault_d;
      asm_q         <= asm_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
      mem_write_q   <= mem_write_d;
      mem_read_q    <= mem_read_d;
      mem_type_q    <= mem_type_d;
`ifndef MISALIGN_TRAP_EN
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      beat_q        <= beat_d;
`endif
    end
  end

  logic [DATA_WIDTH-1:0] ext_data;

  load_extend u_extend (
    .funct3_i (funct3_q),
    .data_i   (asm_q),
    .data_o   (ext_data)
  );

  // Response fields decode straight from registered state, so the pulse is
  // glitch-free and lasts exactly the RESP cycle.
  assign req_ready       = (state_q == IDLE);
  assign rsp_valid       = (state_q == RESP);
  assign rsp_fault       = (state_q == RESP) && fault_q;
  assign rsp_rdata       = ((state_q == RESP) && !write_q && !fault_q) ? ext_data : '0;
  assign mem_addr        = mem_addr_q;
  assign mem_data_in     = mem_data_in_q;
  assign mem_write       = mem_write_q;
  assign mem_read        = mem_read_q;
  assign mem_access_type = mem_type_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic        mem_write;
  logic        mem_read;
  logic [1:0]  mem_access_type;
  logic [31:0] mem_data_out;

  int n_tests = 0;
  int n_fail  = 0;

  load_store_unit #(.DATA_WIDTH(32), .WORDS(1024)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_funct3      (req_funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_rdata       (rsp_rdata),
    .rsp_fault       (rsp_fault),
    .mem_addr        (mem_addr),
    .mem_data_in     (mem_data_in),
    .mem_write       (mem_write),
    .mem_read        (mem_read),
    .mem_access_type (mem_access_type),
    .mem_data_out    (mem_data_out)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // Byte-addressed memory model: combinational zero-extended read, write at posedge.
  logic [7:0]  mem [0:4095];
  logic        mem_clear;
  logic [11:0] ma;
  assign ma = mem_addr[11:0];

  always_comb begin
    mem_data_out = 32'h0;
    if (mem_read) begin
      case (mem_access_type)
        BYTE_MEM_ACCESS: mem_data_out = {24'h0, mem[ma]};
        HALF_MEM_ACCESS: mem_data_out = {16'h0, mem[ma + 12'd1], mem[ma]};
        default:         mem_data_out = {mem[ma + 12'd3], mem[ma + 12'd2],
                                         mem[ma + 12'd1], mem[ma]};
      endcase
    end
  end

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
    end else if (mem_write) begin
      mem[ma] <= mem_data_in[7:0];
      if (mem_access_type != BYTE_MEM_ACCESS) mem[ma + 12'd1] <= mem_data_in[15:8];
      if (mem_access_type == WORD_MEM_ACCESS) begin
        mem[ma + 12'd2] <= mem_data_in[23:16];
        mem[ma + 12'd3] <= mem_data_in[31:24];
      end
    end
  end

  // Scoreboard
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act);
    logic [31:0] exp;
    exp = exp_q.pop_front();
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Vector table
  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_fault;
    int          exp_lat;
    int          exp_beats;
    logic [1:0]  exp_type;
    logic [31:0] exp_maddr;
    logic [31:0] exp_mdin;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic fault, input int lat, input int beats,
                              input logic [1:0] typ, input logic [31:0] maddr,
                              input logic [31:0] mdin);
    vec_t v;
    v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.exp_rdata = rdata;
    v.exp_fault = fault; v.exp_lat = lat; v.exp_beats = beats; v.exp_type = typ;
    v.exp_maddr = maddr; v.exp_mdin = mdin;
    vecs.push_back(v);
  endfunction

  // Driver: one request, monitored from accept to the response pulse.
  task automatic do_req(input string tag, input vec_t v);
    int lat, rd_cyc, wr_cyc, bad_beat;
    logic [31:0] rdata, first_mdin;
    logic fault, busy;
    lat = 0; rd_cyc = 0; wr_cyc = 0; bad_beat = 0;
    rdata = 32'hx; fault = 1'bx; first_mdin = 32'h0; busy = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = v.wr; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata;
    exp_q.push_back(32'd1);
    check({tag, " ready"}, {31'h0, req_ready});
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0;
        busy = req_ready;
      end
      if (mem_read || mem_write) begin
        if (mem_addr !== v.exp_maddr + 32'(rd_cyc + wr_cyc)) bad_beat++;
        if (mem_access_type !== v.exp_type) bad_beat++;
        if (rd_cyc + wr_cyc == 0) first_mdin = mem_data_in;
        if (mem_read) rd_cyc++;
        if (mem_write) wr_cyc++;
      end
      if (rsp_valid) begin
        lat = k; rdata = rsp_rdata; fault = rsp_fault;
        break;
      end
    end
    exp_q.push_back(32'd0);              check({tag, " busy"},    {31'h0, busy});
    exp_q.push_back(32'(v.exp_lat));     check({tag, " latency"}, 32'(lat));
    exp_q.push_back(v.exp_rdata);        check({tag, " rdata"},   rdata);
    exp_q.push_back({31'h0, v.exp_fault}); check({tag, " fault"}, {31'h0, fault});
    exp_q.push_back(v.wr ? 32'd0 : 32'(v.exp_beats)); check({tag, " reads"},  32'(rd_cyc));
    exp_q.push_back(v.wr ? 32'(v.exp_beats) : 32'd0); check({tag, " writes"}, 32'(wr_cyc));
    exp_q.push_back(32'd0);              check({tag, " beat_addr_type"}, 32'(bad_beat));
    if (v.exp_beats > 0) begin
      exp_q.push_back(v.exp_mdin);       check({tag, " mem_data_in"}, first_mdin);
    end
    @(negedge clk);
    exp_q.push_back(32'd0);              check({tag, " pulse_end"}, {31'h0, rsp_valid});
    exp_q.push_back(32'd1);              check({tag, " ready_again"}, {31'h0, req_ready});
  endtask

  task automatic load_byte(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    vec_t v;
    v.wr = 1'b0; v.f3 = F3_LBU; v.addr = addr; v.wdata = 32'h0; v.exp_rdata = exp;
    v.exp_fault = 1'b0; v.exp_lat = 2; v.exp_beats = 1; v.exp_type = BYTE_MEM_ACCESS;
    v.exp_maddr = addr; v.exp_mdin = 32'h0;
    do_req(tag, v);
  endtask

  initial begin
    rst_n = 1'b0; mem_clear = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;

    add(1'b1, F3_SW,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1, WORD_MEM_ACCESS, 32'h10, 32'hDEADBEEF);
    add(1'b0, F3_LW,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2, 1, WORD_MEM_ACCESS, 32'h10, 32'h0);
    add(1'b0, F3_LB,  32'h13, 32'h0,        32'hFFFFFFDE, 1'b0, 2, 1, BYTE_MEM_ACCESS, 32'h13, 32'h0);
    add(1'b0, F3_LBU, 32'h13, 32'h0,        32'h000000DE, 1'b0, 2, 1, BYTE_MEM_ACCESS, 32'h13, 32'h0);
    add(1'b0, F3_LH,  32'h12, 32'h0,        32'hFFFFDEAD, 1'b0, 2, 1, HALF_MEM_ACCESS, 32'h12, 32'h0);
    add(1'b0, F3_LHU, 32'h10, 32'h0,        32'h0000BEEF, 1'b0, 2, 1, HALF_MEM_ACCESS, 32'h10, 32'h0);
`ifndef MISALIGN_TRAP_EN
    add(1'b1, F3_SW,  32'h21, 32'h11223344, 32'h0,        1'b0, 5, 4, BYTE_MEM_ACCESS, 32'h21, 32'h00000044);
    add(1'b0, F3_LW,  32'h21, 32'h0,        32'h11223344, 1'b0, 5, 4, BYTE_MEM_ACCESS, 32'h21, 32'h0);
    add(1'b0, F3_LH,  32'h23, 32'h0,        32'h00001122, 1'b0, 3, 2, BYTE_MEM_ACCESS, 32'h23, 32'h0);
    add(1'b0, F3_LH,  32'h11, 32'h0,        32'hFFFFADBE, 1'b0, 3, 2, BYTE_MEM_ACCESS, 32'h11, 32'h0);
`else
    add(1'b1, F3_SW,  32'h21, 32'h11223344, 32'h0,        1'b1, 1, 0, WORD_MEM_ACCESS, 32'h0,  32'h0);
    add(1'b0, F3_LW,  32'h21, 32'h0,        32'h0,        1'b1, 1, 0, WORD_MEM_ACCESS, 32'h0,  32'h0);
    add(1'b0, F3_LH,  32'h23, 32'h0,        32'h0,        1'b1, 1, 0, WORD_MEM_ACCESS, 32'h0,  32'h0);
    add(1'b0, F3_LH,  32'h11, 32'h0,        32'h0,        1'b1, 1, 0, WORD_MEM_ACCESS, 32'h0,  32'h0);
    add(1'b0, F3_LW,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2, 1, WORD_MEM_ACCESS, 32'h10, 32'h0);
`endif
    add(1'b0, F3_LW,  32'hFFE,      32'h0,  32'h0, 1'b1, 1, 0, WORD_MEM_ACCESS, 32'h0, 32'h0);
    add(1'b0, 3'b011, 32'h10,       32'h0,  32'h0, 1'b1, 1, 0, WORD_MEM_ACCESS, 32'h0, 32'h0);
    add(1'b1, 3'b100, 32'h10,       32'h55, 32'h0, 1'b1, 1, 0, WORD_MEM_ACCESS, 32'h0, 32'h0);
    add(1'b0, F3_LB,  32'h1000,     32'h0,  32'h0, 1'b1, 1, 0, WORD_MEM_ACCESS, 32'h0, 32'h0);
    add(1'b0, F3_LW,  32'hFFFFFFFF, 32'h0,  32'h0, 1'b1, 1, 0, WORD_MEM_ACCESS, 32'h0, 32'h0);
    add(1'b0, F3_LBU, 32'hFFF,      32'h0,  32'h0, 1'b0, 2, 1, BYTE_MEM_ACCESS, 32'hFFF, 32'h0);
    add(1'b0, F3_LW,  32'hFFC,      32'h0,  32'h0, 1'b0, 2, 1, WORD_MEM_ACCESS, 32'hFFC, 32'h0);
    add(1'b1, F3_SH,  32'h40, 32'h12345678, 32'h0,        1'b0, 2, 1, HALF_MEM_ACCESS, 32'h40, 32'h00005678);
    add(1'b0, F3_LW,  32'h40, 32'h0,        32'h00005678, 1'b0, 2, 1, WORD_MEM_ACCESS, 32'h40, 32'h0);
    add(1'b1, F3_SB,  32'h50, 32'h123456AB, 32'h0,        1'b0, 2, 1, BYTE_MEM_ACCESS, 32'h50, 32'h000000AB);
    add(1'b0, F3_LB,  32'h50, 32'h0,        32'hFFFFFFAB, 1'b0, 2, 1, BYTE_MEM_ACCESS, 32'h50, 32'h0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    exp_q.push_back(32'd1);          check("reset req_ready", {31'h0, req_ready});
    exp_q.push_back(32'd0);          check("reset rsp_valid", {31'h0, rsp_valid});
    exp_q.push_back(32'd0);          check("reset rsp_rdata", rsp_rdata);
    exp_q.push_back(32'd0);          check("reset rsp_fault", {31'h0, rsp_fault});
    exp_q.push_back(32'd0);          check("reset mem_rw", {30'h0, mem_read, mem_write});
    exp_q.push_back(32'd0);          check("reset mem_addr", mem_addr);
    exp_q.push_back(32'd0);          check("reset mem_data_in", mem_data_in);
    exp_q.push_back({30'h0, WORD_MEM_ACCESS}); check("reset mem_type", {30'h0, mem_access_type});
    rst_n = 1'b1; mem_clear = 1'b0;

    for (int i = 0; i < vecs.size(); i++) do_req($sformatf("v%0d", i), vecs[i]);

`ifndef MISALIGN_TRAP_EN
    // Reset during beat 2 (address 0x33) of a split store.
    begin
      logic seen_rsp;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = F3_SW;
      req_addr = 32'h31; req_wdata = 32'hAABBCCDD;
      @(posedge clk);
      @(negedge clk); req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      exp_q.push_back(32'h33);       check("rst beat2 addr", mem_addr);
      rst_n = 1'b0;
      #1;
      exp_q.push_back(32'd0);        check("rst mem_rw", {30'h0, mem_read, mem_write});
      exp_q.push_back(32'd0);        check("rst mem_addr", mem_addr);
      exp_q.push_back(32'd0);        check("rst mem_data_in", mem_data_in);
      exp_q.push_back(32'd0);        check("rst rsp", {31'h0, rsp_valid} | rsp_rdata | {31'h0, rsp_fault});
      seen_rsp = 1'b0;
      repeat (3) begin
        @(posedge clk); #1 seen_rsp = seen_rsp | rsp_valid;
      end
      @(negedge clk); rst_n = 1'b1;
      repeat (3) begin
        @(posedge clk); #1 seen_rsp = seen_rsp | rsp_valid;
      end
      exp_q.push_back(32'd0);        check("rst no rsp", {31'h0, seen_rsp});
      @(negedge clk);
      exp_q.push_back(32'd1);        check("rst req_ready", {31'h0, req_ready});
      load_byte("rst lbu31", 32'h31, 32'h000000DD);
      load_byte("rst lbu32", 32'h32, 32'h000000CC);
      load_byte("rst lbu33", 32'h33, 32'h00000000);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute stage and the data `memory` block. Turns a load/store request (funct3, byte address, store data) into a legal sequence of memory port transactions.
- Sign/zero-extends load data and returns a single-cycle registered response.
- Misaligned halfword/word accesses are split into sequential byte beats.
- Out-of-range addresses and illegal funct3 raise a fault without touching memory.

Parameters:
- DATA_WIDTH, 32, data/address width; only 32 supported.
- WORDS, 1024, memory depth in 32-bit words; legal byte range is 0 to WORDS*4-1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle, can accept
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I load/store funct3
- req_addr  in  DATA_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, low bytes used
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and faults
- rsp_fault  out  1  access fault, valid with rsp_valid
- mem_addr  out  DATA_WIDTH  to memory addr
- mem_data_in  out  DATA_WIDTH  to memory data_in
- mem_write  out  1  to memory mem_write
- mem_read  out  1  to memory mem_read
- mem_access_type  out  2  to memory mem_access_type
- mem_data_out  in  DATA_WIDTH  from memory data_out; combinational, zero-extended

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_fault=0, mem_read=0, mem_write=0, mem_addr=0, mem_data_in=0, mem_access_type=WORD_MEM_ACCESS.
- Memory-side outputs are registered.
- Memory contract: a read returns data the same cycle mem_read/mem_addr are driven; a write commits at the posedge while mem_write=1.
- States: IDLE, ACCESS, SPLIT, RESP.
- IDLE: req_ready=1. Handshake at posedge with req_valid&&req_ready latches the request, then:
  - fault → RESP
  - aligned → ACCESS
  - misaligned → SPLIT with beat=0
- Alignment: byte always aligned; half if addr[0]=0; word if addr[1:0]=0.
- Fault conditions (checked at accept):
  - funct3 not in {LB, LH, LW, LBU, LHU} for loads, or not in {SB, SH, SW} for stores;
  - any accessed byte address ≥ WORDS*4.
  - Fault path: no mem_read/mem_write ever asserted; rsp_fault=1, rsp_rdata=0.
- ACCESS: one cycle. mem_read or mem_write=1, mem_access_type from size, mem_addr=latched addr. mem_data_in = wdata, zero-masked to size. Load data captured at the cycle's end → RESP.
- SPLIT: one byte beat per cycle for `size` beats (2 or 4).
  - Beat k: mem_addr=addr+k, BYTE_MEM_ACCESS, store byte = wdata[8k+7:8k].
  - Load byte k is captured into assembly register bits [8k+7:8k], little-endian.
  - 2-bit beat counter; after the last beat → RESP.
- RESP: rsp_valid=1 for exactly one cycle. rsp_rdata is sign-extended for LB/LH, zero-extended for LBU/LHU/LW; 0 for stores. → IDLE. req_ready=0 in every state but IDLE.
- Latency (accept edge = N):
  - aligned: memory cycle N+1, rsp in N+2;
  - split: memory cycles N+1..N+size, rsp in N+size+1;
  - fault: rsp in N+1.
- No response backpressure; the consumer must take rsp_valid when it pulses.
- Reset mid-operation: immediate return to IDLE with reset values. Beats already committed stay in memory; no response is issued.
- Address wrap: addr+k is computed in DATA_WIDTH bits. Any wrap is caught by the range check, so a wrapped access always faults.

Optional Feature:
- MISALIGN_TRAP_EN defined: misaligned half/word accesses fault exactly like out-of-range accesses (rsp in N+1, no memory traffic). The SPLIT state and beat counter are not compiled in.
- Undefined: misaligned accesses are split as above.

Decomposition:
- Shared package:
  - existing BYTE_MEM_ACCESS/HALF_MEM_ACCESS/WORD_MEM_ACCESS constants;
  - new funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW);
  - lsu_state_t enum.
- Sub-module `load_extend`: combinational funct3-driven sign/zero extension of the assembled read word; shared with any future load path.

Test Plan:
- SW 0x10 0xDEADBEEF, then LW 0x10 → one mem_write cycle (WORD, addr 0x10); load rsp_rdata=0xDEADBEEF, rsp_fault=0, rsp_valid at accept+2.
- LB 0x13 → 0xFFFFFFDE; LBU 0x13 → 0x000000DE; LH 0x12 → 0xFFFFDEAD; LHU 0x10 → 0x0000BEEF.
- SW 0x21 0x11223344 → four BYTE writes: 0x21=0x44, 0x22=0x33, 0x23=0x22, 0x24=0x11. LW 0x21 → 0x11223344 at accept+5; LH 0x23 → 0x00001122.
- LW 0xFFE (WORDS=1024) and load funct3=3'b011 → rsp_fault=1, rsp_rdata=0 at accept+1, mem_read/mem_write never high.
- Pull rst_n low during beat 2 of misaligned SW 0x31 0xAABBCCDD → all outputs zero immediately, no rsp_valid. After release req_ready=1; LBU 0x31=0xDD, 0x32=0xCC, 0x33=0x00.
- With MISALIGN_TRAP_EN: LW 0x21 → rsp_fault=1 at accept+1, no memory traffic; aligned LW 0x10 still returns 0xDEADBEEF.
